// File: rtl/register_file_mp.sv
// Multi-port integer register file: two write ports, three combinational read
// ports with write bypass, pending-write scoreboard and sequenced post-reset clear.
module register_file_mp #(
    parameter int unsigned WORDSIZE = 64,
    parameter int unsigned ADDRBITS = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                ready,
    input  logic                write_en_a,
    input  logic                write_en_b,
    input  logic [ADDRBITS-1:0] write_addr_a,
    input  logic [ADDRBITS-1:0] write_addr_b,
    input  logic [WORDSIZE-1:0] write_data_a,
    input  logic [WORDSIZE-1:0] write_data_b,
    input  logic [ADDRBITS-1:0] addr_a,
    input  logic [ADDRBITS-1:0] addr_b,
    input  logic [ADDRBITS-1:0] addr_d,
    output logic [WORDSIZE-1:0] data_a,
    output logic [WORDSIZE-1:0] data_b,
    output logic [WORDSIZE-1:0] data_d,
    input  logic                issue_en,
    input  logic [ADDRBITS-1:0] issue_addr,
    output logic                busy_a,
    output logic                busy_b
);

    localparam int unsigned NREGS    = 2 ** ADDRBITS;
    localparam int unsigned NRD      = 3;
    localparam logic [ADDRBITS-1:0] LAST_IDX = ADDRBITS'(NREGS - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state;
    state_t                state_nx;
    logic [ADDRBITS-1:0]   cnt;
    logic [ADDRBITS-1:0]   cnt_nx;
    logic                  ready_nx;
    logic [NREGS-1:0]      pending;
    logic [NREGS-1:0]      pending_nx;
    logic [WORDSIZE-1:0]   mem [NREGS];

    logic                  run;
    logic                  store_a;
    logic                  store_b;
    logic                  issue_ok;
    logic [ADDRBITS-1:0]   raddr [NRD];
    logic [WORDSIZE-1:0]   rdata [NRD];
    logic [NRD-1:0]        rbusy;

    assign run = (state == RUN);

    // Qualified write/issue strobes; register 0 is immutable when hardwired.
    always_comb begin
        store_a  = run && write_en_a && !(ZERO_REG && (write_addr_a == '0));
        store_b  = run && write_en_b && !(ZERO_REG && (write_addr_b == '0));
        issue_ok = run && issue_en   && !(ZERO_REG && (issue_addr   == '0));
    end

    // Control state register; reset leaves storage untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            cnt     <= '0;
            ready   <= 1'b0;
            pending <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            ready   <= ready_nx;
            pending <= pending_nx;
        end
    end

    // Next state: walk the clear counter, then track pending writes in RUN.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        ready_nx   = ready;
        pending_nx = pending;
        case (state)
            CLEAR: begin
                if (cnt == LAST_IDX) begin
                    state_nx = RUN;
                    ready_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + ADDRBITS'(1);
                end
            end
            RUN: begin
                if (write_en_a) pending_nx[write_addr_a] = 1'b0;
                if (write_en_b) pending_nx[write_addr_b] = 1'b0;
                // A freshly issued producer outranks a retiring one.
                if (issue_ok) pending_nx[issue_addr] = 1'b1;
            end
            default: begin
                state_nx = CLEAR;
                cnt_nx   = '0;
                ready_nx = 1'b0;
            end
        endcase
        if (ZERO_REG) pending_nx[0] = 1'b0;
    end

    // Storage: sequenced clear, then port A followed by port B so B wins ties.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else begin
                if (store_a) mem[write_addr_a] <= write_data_a;
                if (store_b) mem[write_addr_b] <= write_data_b;
            end
        end
    end

    always_comb begin
        raddr[0] = addr_a;
        raddr[1] = addr_b;
        raddr[2] = addr_d;
    end

    // Read ports: zero register, then B bypass, then A bypass, then storage.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rdata[i] = '0;
            rbusy[i] = 1'b0;
            if (run) begin
                if (ZERO_REG && (raddr[i] == '0)) begin
                    rdata[i] = '0;
                end else if (write_en_b && (write_addr_b == raddr[i])) begin
                    rdata[i] = write_data_b;
                end else if (write_en_a && (write_addr_a == raddr[i])) begin
                    rdata[i] = write_data_a;
                end else begin
                    rdata[i] = mem[raddr[i]];
                end
                rbusy[i] = pending[raddr[i]]
                         && !(write_en_a && (write_addr_a == raddr[i]))
                         && !(write_en_b && (write_addr_b == raddr[i]));
            end
        end
    end

    assign data_a = rdata[0];
    assign data_b = rdata[1];
    assign data_d = rdata[2];
    assign busy_a = rbusy[0];
    assign busy_b = rbusy[1];

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed steps plus randomized
// traffic compared against an array-based reference model.
module tb_register_file_mp;

    localparam int unsigned W  = 64;
    localparam int unsigned AB = 5;
    localparam int unsigned N  = 32;
    localparam logic [W-1:0] PAT = 64'hAAAA_AAAA_AAAA_AAAA;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ready;
    logic          write_en_a, write_en_b;
    logic [AB-1:0] write_addr_a, write_addr_b;
    logic [W-1:0]  write_data_a, write_data_b;
    logic [AB-1:0] addr_a, addr_b, addr_d;
    logic [W-1:0]  data_a, data_b, data_d;
    logic          issue_en;
    logic [AB-1:0] issue_addr;
    logic          busy_a, busy_b;

    int checks   = 0;
    int failures = 0;

    // Reference model: storage, pending flags, edges since reset release.
    logic [W-1:0] mem_m [N];
    bit           pend_m [N];
    int           rel_m;
    bit           ready_m;

    always #5 clk = ~clk;

    register_file_mp #(.WORDSIZE(W), .ADDRBITS(AB), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ready(ready),
        .write_en_a(write_en_a), .write_en_b(write_en_b),
        .write_addr_a(write_addr_a), .write_addr_b(write_addr_b),
        .write_data_a(write_data_a), .write_data_b(write_data_b),
        .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d),
        .data_a(data_a), .data_b(data_b), .data_d(data_d),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .busy_a(busy_a), .busy_b(busy_b)
    );

    function automatic logic [W-1:0] exp_data(input logic [AB-1:0] a);
        if (!ready_m || a == 0) return '0;
        if (write_en_b && write_addr_b == a) return write_data_b;
        if (write_en_a && write_addr_a == a) return write_data_a;
        return mem_m[a];
    endfunction

    function automatic logic exp_busy(input logic [AB-1:0] a);
        if (!ready_m) return 1'b0;
        if ((write_en_a && write_addr_a == a) || (write_en_b && write_addr_b == a)) return 1'b0;
        return pend_m[a];
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one rising edge to the model, using the inputs present at that edge.
    task automatic model_edge();
        if (!rst_n) begin
            rel_m   = 0;
            ready_m = 1'b0;
            foreach (pend_m[i]) pend_m[i] = 1'b0;
        end else if (!ready_m) begin
            mem_m[rel_m] = '0;
            rel_m++;
            if (rel_m == N) ready_m = 1'b1;
        end else begin
            if (write_en_a) pend_m[write_addr_a] = 1'b0;
            if (write_en_b) pend_m[write_addr_b] = 1'b0;
            if (write_en_a && write_addr_a != 0) mem_m[write_addr_a] = write_data_a;
            if (write_en_b && write_addr_b != 0) mem_m[write_addr_b] = write_data_b;
            if (issue_en && issue_addr != 0) pend_m[issue_addr] = 1'b1;
        end
    endtask

    task automatic settle(input string tag);
        #1;
        chk({tag, ":ready"},  W'(ready),  W'(ready_m));
        chk({tag, ":data_a"}, data_a,     exp_data(addr_a));
        chk({tag, ":data_b"}, data_b,     exp_data(addr_b));
        chk({tag, ":data_d"}, data_d,     exp_data(addr_d));
        chk({tag, ":busy_a"}, W'(busy_a), W'(exp_busy(addr_a)));
        chk({tag, ":busy_b"}, W'(busy_b), W'(exp_busy(addr_b)));
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic tick(input string tag);
        settle(tag);
        edge_step();
    endtask

    task automatic idle();
        write_en_a = 0; write_en_b = 0; issue_en = 0;
        write_addr_a = '0; write_addr_b = '0; issue_addr = '0;
        write_data_a = '0; write_data_b = '0;
    endtask

    task automatic randomize_inputs(input bit narrow);
        write_en_a   = 1'($urandom_range(0, 1));
        write_en_b   = 1'($urandom_range(0, 1));
        issue_en     = 1'($urandom_range(0, 1));
        write_data_a = {$urandom, $urandom};
        write_data_b = {$urandom, $urandom};
        write_addr_a = narrow ? AB'($urandom_range(0, 7)) : AB'($urandom);
        write_addr_b = narrow ? AB'($urandom_range(0, 7)) : AB'($urandom);
        issue_addr   = narrow ? AB'($urandom_range(0, 7)) : AB'($urandom);
        addr_a       = narrow ? AB'($urandom_range(0, 7)) : AB'($urandom);
        addr_b       = narrow ? AB'($urandom_range(0, 7)) : AB'($urandom);
        addr_d       = AB'($urandom);
    endtask

    initial begin
        foreach (mem_m[i]) mem_m[i] = 'x;
        foreach (pend_m[i]) pend_m[i] = 1'b0;
        rel_m = 0; ready_m = 1'b0;
        idle();
        addr_a = '0; addr_b = '0; addr_d = '0;
        rst_n = 1'b0;
        edge_step();

        // Initial reset and clear, then fill every register with a pattern.
        tick("rst0");
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) tick("clear0");
        for (int i = 1; i < N; i++) begin
            write_en_a = 1; write_addr_a = AB'(i); write_data_a = PAT;
            addr_a = AB'(i); addr_b = AB'(i);
            tick("fill");
        end
        idle();

        // Reset held two edges; ready must rise after exactly 32 edges.
        rst_n = 1'b0;
        tick("rst1");
        tick("rst1");
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            addr_a = AB'(i); addr_b = AB'(N - 1 - i); addr_d = AB'(i);
            settle("clear1");
            if (i == N - 1) chk("ready_low_edge31", W'(ready), '0);
            edge_step();
        end
        chk("ready_high_edge32", W'(ready), 1);
        for (int i = 0; i < N; i++) begin
            addr_a = AB'(i); addr_b = AB'(i); addr_d = AB'(i);
            settle("zeroed");
            chk("zeroed_const", data_d, '0);
            edge_step();
        end

        // Basic write/read and port-B bypass.
        write_en_a = 1; write_addr_a = 5'd4; write_data_a = 64'd5;
        addr_a = 5'd4; addr_b = 5'd7; addr_d = 5'd0;
        tick("wr_x4");
        idle();
        settle("rd_x4");
        chk("x4_const", data_a, 64'd5);
        chk("x7_zero", data_b, '0);
        write_en_b = 1; write_addr_b = 5'd7; write_data_b = 64'hB;
        settle("byp_x7");
        chk("x7_bypass", data_b, 64'hB);
        edge_step();
        idle();
        settle("rd_x7");
        chk("x7_stored", data_b, 64'hB);
        edge_step();

        // Dual write conflict and writes to x0.
        write_en_a = 1; write_addr_a = 5'd9; write_data_a = 64'd1;
        write_en_b = 1; write_addr_b = 5'd9; write_data_b = 64'd2;
        addr_a = 5'd9; addr_b = 5'd9; addr_d = 5'd9;
        tick("dual_x9");
        idle();
        settle("rd_x9");
        chk("x9_portb_wins", data_d, 64'd2);
        edge_step();
        write_en_a = 1; write_addr_a = 5'd0; write_data_a = 64'hFF;
        write_en_b = 1; write_addr_b = 5'd0; write_data_b = 64'hFF;
        addr_a = 5'd0; addr_b = 5'd0; addr_d = 5'd0;
        settle("wr_x0");
        chk("x0_no_bypass", data_a | data_b | data_d, '0);
        edge_step();
        idle();
        tick("rd_x0");

        // Scoreboard: issue, satisfying write, and issue racing a write.
        issue_en = 1; issue_addr = 5'd12; addr_a = 5'd12; addr_b = 5'd12;
        tick("iss_x12");
        idle();
        settle("busy_x12");
        chk("busy_after_issue", W'(busy_a), 1);
        edge_step();
        write_en_a = 1; write_addr_a = 5'd12; write_data_a = 64'h33;
        settle("sat_x12");
        chk("busy_satisfied", W'(busy_a), 0);
        chk("sat_bypass", data_a, 64'h33);
        edge_step();
        idle();
        settle("cleared_x12");
        chk("pending_cleared", W'(busy_a), 0);
        edge_step();
        issue_en = 1; issue_addr = 5'd12;
        write_en_b = 1; write_addr_b = 5'd12; write_data_b = 64'h44;
        tick("race_x12");
        idle();
        settle("race_after");
        chk("issue_wins", W'(busy_a), 1);
        edge_step();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            randomize_inputs(i % 2 == 0);
            tick("rand");
        end

        // Mid-clear reset with traffic driven throughout CLEAR.
        rst_n = 1'b0;
        randomize_inputs(1'b1);
        tick("rst2");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            randomize_inputs(1'b1);
            tick("clear2a");
        end
        rst_n = 1'b0;
        randomize_inputs(1'b1);
        tick("midrst");
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            randomize_inputs(1'b0);
            settle("clear2b");
            chk("ready_mid_clear", W'(ready), '0);
            edge_step();
        end
        idle();
        chk("ready_after_restart", W'(ready), 1);
        for (int i = 0; i < N; i++) begin
            addr_a = AB'(i); addr_b = AB'(i); addr_d = AB'(i);
            settle("post_clear");
            chk("post_clear_zero", data_a, '0);
            chk("post_clear_idle", W'(busy_a), '0);
            edge_step();
        end

        for (int i = 0; i < 200; i++) begin
            randomize_inputs(1'b1);
            tick("rand2");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
